// File: rtl/sub16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sub16_pkg
// Brief   : Shared widths, FSM state and nibble-index types for sub16_serial.
// Revision: 1.0 - initial release
// ============================================================================
package sub16_pkg;

    localparam int W    = 16;
    localparam int NIB  = 4;
    localparam int NNIB = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_t;

    typedef logic [1:0] nib_idx_t;

    localparam nib_idx_t LAST_IDX = nib_idx_t'(NNIB - 1);

endpackage
`default_nettype wire

// File: rtl/sub4_slice.sv
`default_nettype none
// ============================================================================
// Module  : sub4_slice
// Brief   : Combinational 4-bit subtract with borrow, built as a + ~b + ~bin.
// Revision: 1.0 - initial release
// ============================================================================
module sub4_slice
    import sub16_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           bin,
    output logic [NIB-1:0] diff,
    output logic           bout
);

    logic [NIB:0] w_sum;

    // Carry-out of the complemented add is the inverse of the borrow-out.
    assign w_sum = {1'b0, a} + {1'b0, ~b} + {{NIB{1'b0}}, ~bin};
    assign diff  = w_sum[NIB-1:0];
    assign bout  = ~w_sum[NIB];

endmodule
`default_nettype wire

// File: rtl/sub16_serial.sv
`default_nettype none
// ============================================================================
// Module  : sub16_serial
// Brief   : Nibble-serial 16-bit subtractor X = A - B - bin with flags.
// Revision: 1.0 - initial release
// ============================================================================
module sub16_serial
    import sub16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] X,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    sub_state_t     r_state;
    nib_idx_t       r_idx;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_partial;
    logic           r_borrow;

    logic [NIB-1:0] w_a_nib;
    logic [NIB-1:0] w_b_nib;
    logic [NIB-1:0] w_nib;
    logic           w_borrow_nxt;
    logic [W-1:0]   w_x_final;

    assign w_a_nib   = r_a[{r_idx, 2'b00} +: NIB];
    assign w_b_nib   = r_b[{r_idx, 2'b00} +: NIB];
    // Meaningful only on the last nibble, when the lower nibbles are complete.
    assign w_x_final = {w_nib, r_partial[W-NIB-1:0]};

    sub4_slice u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .bin  (r_borrow),
        .diff (w_nib),
        .bout (w_borrow_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_borrow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            X         <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_partial <= '0;
                        r_borrow  <= bin;
                        r_idx     <= '0;
                        busy      <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_partial[{r_idx, 2'b00} +: NIB] <= w_nib;
                    r_borrow <= w_borrow_nxt;
                    if (r_idx == LAST_IDX) begin
                        X       <= w_x_final;
                        bout    <= w_borrow_nxt;
                        zero    <= (w_x_final == '0);
                        ovf     <= (r_a[W-1] != r_b[W-1]) && (w_x_final[W-1] != r_a[W-1]);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub16_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub16_serial
// Brief   : Directed and random bench for sub16_serial against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sub16_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, zero, ovf;
    logic [15:0] X;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_x;
    logic        exp_bout, exp_zero, exp_ovf;

    always #5 clk = ~clk;

    sub16_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .X     (X),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer subtraction, no slicing.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int d;
        d        = int'(a) - int'(b) - int'(bi);
        exp_x    = 16'(d);
        exp_bout = (d < 0);
        exp_zero = (exp_x == 16'h0000);
        exp_ovf  = (a[15] != b[15]) && (exp_x[15] != a[15]);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_x"},    32'(X),    32'(exp_x));
        check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        check({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
    endtask

    // Counts negedges until done is seen; -1 on timeout.
    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!seen && done) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi);
        int cyc;
        model(a, b, bi);
        @(negedge clk);
        A = a; B = b; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); bin = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd4);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check_results(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(X), 32'(exp_x));
    endtask

    initial begin
        int cyc;
        int dcount;
        logic [15:0] ra, rb;
        logic        rbi;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_x", 32'(X), 32'd0);
        check("rst_flags", {28'd0, bout, zero, ovf, done}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Directed vectors
        do_op("d1", 16'h1234, 16'h0234, 1'b0);
        check("d1_const", 32'(X), 32'h1000);
        do_op("d2", 16'h0000, 16'h0001, 1'b0);
        check("d2_const", 32'(X), 32'hFFFF);
        do_op("d3", 16'h8000, 16'h0001, 1'b0);
        do_op("d4", 16'h7FFF, 16'hFFFF, 1'b0);
        do_op("d5", 16'h0005, 16'h0004, 1'b1);
        check("d5_zero_const", 32'(zero), 32'd1);
        do_op("d6", 16'h0000, 16'h0000, 1'b1);

        // Start while busy ignored; then back-to-back from the done cycle
        model(16'hA5C3, 16'h1357, 1'b1);
        @(negedge clk);
        A = 16'hA5C3; B = 16'h1357; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'h0F0F; B = 16'hF0F0; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ign_lat", 32'(cyc), 32'd2);
        check_results("ign");
        A = 16'h4000; B = 16'h4001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_hold_run", 32'(X), 32'(exp_x));
        model(16'h4000, 16'h4001, 1'b0);
        wait_done(cyc);
        check("b2b_gap", 32'(cyc + 1), 32'd5);
        check_results("b2b");

        // Reset mid-RUN aborts
        @(negedge clk);
        A = 16'h1111; B = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_x", 32'(X), 32'd0);
        check("abort_flags", {28'd0, bout, zero, ovf, busy}, 32'd0);
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_nodone", 32'(dcount), 32'd0);
        do_op("post_abort", 16'h3C3C, 16'h1234, 1'b0);

        // Reset wins over start on the same edge
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 16'h0001; B = 16'h0000;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("rst_wins_nodone", 32'(dcount), 32'd0);

        // Random operands
        for (int t = 0; t < 24; t++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            do_op("rnd", ra, rb, rbi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub16_serial.md
# sub16_serial

Sequential 16-bit subtractor computing X = A − B − bin one 4-bit nibble per clock, least-significant nibble first, with a registered borrow chained between nibbles. It is the subtract-direction counterpart of the datapath's 16-bit adder, which is built from four cascaded 4-bit slices. It shares that adder's 4-bit slicing and start/done operand interface so the ALU can issue either operation. Results are flagged (borrow, zero, signed overflow) for the condition-code logic.

## Interface
Parameters:
- none; width fixed at 16, slice width fixed at 4 (package constants)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; accepted only when busy=0
- A  input  16  minuend; sampled on the accepting edge only
- B  input  16  subtrahend; sampled on the accepting edge only
- bin  input  1  borrow-in; sampled on the accepting edge only
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; X and flags valid from this cycle
- X  output  16  difference (A − B − bin) mod 2^16
- bout  output  1  borrow-out; 1 iff A < B + bin (unsigned)
- zero  output  1  X == 0
- ovf  output  1  signed overflow: (A[15] != B[15]) && (X[15] != A[15])

## Operation
- FSM states:
  - IDLE, then RUN with nibble index 0..3
  - IDLE -> RUN on start=1
  - RUN stays in RUN while index < 3, index increments each cycle
  - RUN at index 3 -> IDLE with done=1
- Accept:
  - Latch A, B and bin into internal operand registers.
  - Clear the partial-result register and set the borrow register to bin.
  - Set index to 0 and busy to 1.
- Each RUN cycle:
  - Compute nib = A[4i+3:4i] − B[4i+3:4i] − borrow with the 4-bit slice.
  - Implement the slice as A + ~B + ~borrow: slice carry-out c gives next borrow = ~c.
  - Write nib into partial[4i+3:4i] and register the new borrow.
- Completion edge, after index 3:
  - Copy partial (including the final nibble) to X and the final borrow to bout.
  - Register zero and ovf from the final values.
  - Pulse done, clear busy, return to IDLE.
- X, bout, zero and ovf hold their values until the next completion. They do not change during a later RUN.
- start while busy=1 is ignored: no re-latch and no effect on the in-flight result.
- A, B and bin may change freely after acceptance; only the latched copies are used.

## Timing
- Reset: X=0, bout=0, zero=0, ovf=0, done=0, busy=0, FSM state IDLE, index 0. Reset wins over start on the same edge.
- Reset asserted mid-RUN aborts the operation: no done pulse, and the outputs take their reset values.
- Latency:
  - start high at edge k (in IDLE) -> busy=1 after edge k.
  - Nibbles 0..3 are computed on edges k+1..k+4.
  - done=1 and results valid after edge k+4 for exactly one cycle; busy=0 in that same cycle.
- Back-to-back operation: start may be high in the done cycle and is accepted. Throughput is one result per 5 cycles.
- start held high continuously produces a new acceptance each time the FSM is in IDLE.

## Structure
- Shared package `sub16_pkg`:
  - localparams W=16, NIB=4, NNIB=4
  - FSM state typedef `sub_state_t` {IDLE, RUN}
  - 2-bit index type
- One sub-module, `sub4_slice`: combinational 4-bit subtract with borrow-in and borrow-out (A + ~B + ~bin form).
  - The top level instantiates it once and muxes the operand nibbles by index.
- Top level holds the FSM, operand, partial, borrow and output registers.

## Test plan
- A=0x1234, B=0x0234, bin=0 -> done after edge k+4, X=0x1000, bout=0, zero=0, ovf=0.
- A=0x0000, B=0x0001, bin=0 -> X=0xFFFF, bout=1, zero=0, ovf=0. Exercises borrow ripple through all four nibbles.
- A=0x8000, B=0x0001, bin=0 -> X=0x7FFF, bout=0, ovf=1. Then A=0x7FFF, B=0xFFFF -> X=0x8000, bout=1, ovf=1.
- A=0x0005, B=0x0004, bin=1 -> X=0x0000, zero=1, bout=0. Then A=0x0000, B=0x0000, bin=1 -> X=0xFFFF, bout=1.
- Second start pulse at edge k+2 with different operands -> ignored; result matches the first operands. Then start in the done cycle -> accepted, second done exactly 5 cycles after the first.
- rst at edge k+2 mid-RUN -> no done pulse, all outputs 0, busy=0. A fresh start then completes normally.
